// File: rtl/data_path_pkg.sv
// Shared encodings for the dual-channel arbiter and the data_select mux it feeds.
// Pure definitions; no timing or flow control of its own.
package data_path_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OFFER0 = 2'd1,
    ST_OFFER1 = 2'd2
  } state_e;

  localparam logic SEL_ONE = 1'b0;
  localparam logic SEL_TWO = 1'b1;

  // Choose which slot to offer next; rr breaks the tie when both are full.
  function automatic state_e pick_offer(input logic full0, input logic full1, input logic rr);
    state_e st;
    st = ST_IDLE;
    if (full0 && full1) begin
      st = rr ? ST_OFFER1 : ST_OFFER0;
    end else if (full0) begin
      st = ST_OFFER0;
    end else if (full1) begin
      st = ST_OFFER1;
    end
    return st;
  endfunction

endpackage

// File: rtl/channel_slot.sv
// One-entry valid/ready buffer; data visible the cycle after accept.
// Ready while empty, or while being drained this cycle; a full slot is never overwritten.
module channel_slot #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  drain_i,
  output logic                  ready_o,
  output logic                  full_nxt_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  accept;

  assign ready_o    = rst_n & (~full_q | drain_i);
  assign accept     = valid_i & ready_o;
  assign full_d     = accept | (full_q & ~drain_i);
  assign data_d     = accept ? data_i : data_q;
  assign full_nxt_o = full_d;
  assign data_o     = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/dual_channel_arbiter.sv
// Two buffered channels round-robin arbitrated onto the data_select mux; out_valid one cycle after accept.
// The offer is locked until out_ready fires; one fire per cycle sustained with same-cycle slot refill.
module dual_channel_arbiter
  import data_path_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in0_valid,
  input  logic [DATA_WIDTH-1:0] in0_data,
  output logic                  in0_ready,
  input  logic                  in1_valid,
  input  logic [DATA_WIDTH-1:0] in1_data,
  output logic                  in1_ready,
  output logic [DATA_WIDTH-1:0] data_one,
  output logic [DATA_WIDTH-1:0] data_two,
  output logic                  sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  xfer_cnt0,
  output logic [CNT_WIDTH-1:0]  xfer_cnt1
);

  state_e               state_q, state_d;
  logic                 rr_q, rr_d;
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic                 fire, fire0, fire1;
  logic                 full_nxt0, full_nxt1;

  assign fire  = out_valid & out_ready;
  assign fire0 = fire & (state_q == ST_OFFER0);
  assign fire1 = fire & (state_q == ST_OFFER1);

  channel_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (in0_valid),
    .data_i     (in0_data),
    .drain_i    (fire0),
    .ready_o    (in0_ready),
    .full_nxt_o (full_nxt0),
    .data_o     (data_one)
  );

  channel_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (in1_valid),
    .data_i     (in1_data),
    .drain_i    (fire1),
    .ready_o    (in1_ready),
    .full_nxt_o (full_nxt1),
    .data_o     (data_two)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Re-arbitrate only from IDLE or on a fire; otherwise the current offer is held.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = pick_offer(full_nxt0, full_nxt1, rr_d);
      ST_OFFER0,
      ST_OFFER1: if (fire) state_d = pick_offer(full_nxt0, full_nxt1, rr_d);
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q != ST_IDLE);
    sel       = (state_q == ST_OFFER1) ? SEL_TWO : SEL_ONE;
  end

  always_comb begin
    rr_d   = rr_q;
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (fire0) begin
      rr_d   = 1'b1;
      cnt0_d = cnt0_q + CNT_WIDTH'(1);
    end
    if (fire1) begin
      rr_d   = 1'b0;
      cnt1_d = cnt1_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q   <= 1'b0;
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      rr_q   <= rr_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign xfer_cnt0 = cnt0_q;
  assign xfer_cnt1 = cnt1_q;

endmodule
